// File: rtl/bp_fe_queue_fifo.sv
// Checkpointed fetch-queue FIFO: speculative reads via rptr, retire via cptr, roll/clear support.
// Enqueue visible after 1 cycle; ready_o = ~full computed against cptr, so only commits free space.
module bp_fe_queue_fifo #(
  parameter int els_p = 8,
  parameter int entry_width_p = 32,
  localparam int ptr_width_lp = $clog2(els_p) + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [entry_width_p-1:0] fe_queue_i,
  input  logic                     fe_queue_v_i,
  output logic                     fe_queue_ready_o,
  output logic [entry_width_p-1:0] fe_queue_o,
  output logic                     fe_queue_v_o,
  input  logic                     fe_queue_yumi_i,
  input  logic                     commit_v_i,
  input  logic                     roll_v_i,
  input  logic                     clr_v_i,
  output logic [ptr_width_lp-1:0]  count_o
);

  localparam int idx_w_lp = ptr_width_lp - 1;
  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

  logic [ptr_width_lp-1:0]  wptr_q, wptr_d;
  logic [ptr_width_lp-1:0]  rptr_q, rptr_d;
  logic [ptr_width_lp-1:0]  cptr_q, cptr_d;
  logic [entry_width_p-1:0] mem_q [els_p];
  logic                     full;
  logic                     enq;

  assign full = (wptr_q[idx_w_lp-1:0] == cptr_q[idx_w_lp-1:0])
             && (wptr_q[idx_w_lp] != cptr_q[idx_w_lp]);
  assign enq  = fe_queue_v_i & ~full & ~clr_v_i;

  assign fe_queue_ready_o = ~full;
  assign fe_queue_v_o     = (rptr_q != wptr_q);
  assign fe_queue_o       = mem_q[rptr_q[idx_w_lp-1:0]];
  assign count_o          = wptr_q - cptr_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cptr_d = cptr_q;
    if (clr_v_i) begin
      rptr_d = wptr_q;
      cptr_d = wptr_q;
    end else begin
      if (enq)        wptr_d = wptr_q + ptr_one_lp;
      if (commit_v_i) cptr_d = cptr_q + ptr_one_lp;
      // Roll restores to the post-commit checkpoint; a concurrent yumi is dropped.
      if (roll_v_i)             rptr_d = cptr_d;
      else if (fe_queue_yumi_i) rptr_d = rptr_q + ptr_one_lp;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cptr_q <= cptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq & ~reset_i) mem_q[wptr_q[idx_w_lp-1:0]] <= fe_queue_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o))
        else $error("bp_fe_queue_fifo: yumi while queue empty");
      assert (!(commit_v_i && !clr_v_i && (cptr_q == rptr_q) && !fe_queue_yumi_i))
        else $error("bp_fe_queue_fifo: commit of an unread entry");
    end
  end

endmodule

// File: tb/tb_bp_fe_queue_fifo.sv
// Directed bench for bp_fe_queue_fifo with a 4-deep, 16-bit configuration.
module tb_bp_fe_queue_fifo;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic [15:0] fe_queue_i = '0;
  logic        fe_queue_v_i = 1'b0;
  logic        fe_queue_ready_o;
  logic [15:0] fe_queue_o;
  logic        fe_queue_v_o;
  logic        fe_queue_yumi_i = 1'b0;
  logic        commit_v_i = 1'b0;
  logic        roll_v_i = 1'b0;
  logic        clr_v_i = 1'b0;
  logic [2:0]  count_o;

  int checks = 0;
  int passed = 0;

  bp_fe_queue_fifo #(.els_p(4), .entry_width_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
    .commit_v_i(commit_v_i), .roll_v_i(roll_v_i), .clr_v_i(clr_v_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs, let the edge happen, then return 1ns after it.
  task automatic cyc(input logic v, input logic [15:0] d, input logic y,
                     input logic c, input logic r, input logic cl);
    fe_queue_v_i = v; fe_queue_i = d; fe_queue_yumi_i = y;
    commit_v_i = c; roll_v_i = r; clr_v_i = cl;
    @(posedge clk_i); #1;
    fe_queue_v_i = 1'b0; fe_queue_i = '0; fe_queue_yumi_i = 1'b0;
    commit_v_i = 1'b0; roll_v_i = 1'b0; clr_v_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checks++; if (fe_queue_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", fe_queue_ready_o); else passed++;
    checks++; if (fe_queue_v_o !== 1'b0) $display("FAIL reset_v got %b want 0", fe_queue_v_o); else passed++;
    checks++; if (count_o !== 3'd0) $display("FAIL reset_count got %0d want 0", count_o); else passed++;
    reset_i = 1'b0;
  endtask

  task automatic test_fill_drain;
    cyc(1, 16'hA000, 0, 0, 0, 0);
    checks++; if (fe_queue_v_o !== 1'b1) $display("FAIL fill_first_v got %b want 1", fe_queue_v_o); else passed++;
    checks++; if (fe_queue_o !== 16'hA000) $display("FAIL fill_first_head got %h want a000", fe_queue_o); else passed++;
    cyc(1, 16'hB000, 0, 0, 0, 0);
    cyc(1, 16'hC000, 0, 0, 0, 0);
    checks++; if (fe_queue_ready_o !== 1'b1) $display("FAIL fill_ready3 got %b want 1", fe_queue_ready_o); else passed++;
    cyc(1, 16'hD000, 0, 0, 0, 0);
    checks++; if (fe_queue_ready_o !== 1'b0) $display("FAIL fill_ready4 got %b want 0", fe_queue_ready_o); else passed++;
    checks++; if (count_o !== 3'd4) $display("FAIL fill_count4 got %0d want 4", count_o); else passed++;
    cyc(1, 16'hE000, 0, 0, 0, 0);
    checks++; if (count_o !== 3'd4) $display("FAIL fill_held_count got %0d want 4", count_o); else passed++;
    checks++; if (fe_queue_o !== 16'hA000) $display("FAIL fill_held_head got %h want a000", fe_queue_o); else passed++;
    // yumi alone keeps the slot reserved
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (fe_queue_ready_o !== 1'b0) $display("FAIL yumi_no_free got %b want 0", fe_queue_ready_o); else passed++;
    checks++; if (fe_queue_o !== 16'hB000) $display("FAIL drain_head_b got %h want b000", fe_queue_o); else passed++;
    cyc(0, 0, 0, 1, 0, 0);
    checks++; if (fe_queue_ready_o !== 1'b1) $display("FAIL commit_frees got %b want 1", fe_queue_ready_o); else passed++;
    checks++; if (count_o !== 3'd3) $display("FAIL drain_count3 got %0d want 3", count_o); else passed++;
    cyc(0, 0, 1, 1, 0, 0);
    checks++; if (fe_queue_o !== 16'hC000) $display("FAIL drain_head_c got %h want c000", fe_queue_o); else passed++;
    cyc(0, 0, 1, 1, 0, 0);
    checks++; if (fe_queue_o !== 16'hD000) $display("FAIL drain_head_d got %h want d000", fe_queue_o); else passed++;
    cyc(0, 0, 1, 1, 0, 0);
    checks++; if (fe_queue_v_o !== 1'b0) $display("FAIL drain_empty_v got %b want 0", fe_queue_v_o); else passed++;
    checks++; if (fe_queue_ready_o !== 1'b1) $display("FAIL drain_ready got %b want 1", fe_queue_ready_o); else passed++;
    checks++; if (count_o !== 3'd0) $display("FAIL drain_count0 got %0d want 0", count_o); else passed++;
  endtask

  task automatic test_rollback;
    cyc(1, 16'h1111, 0, 0, 0, 0);
    cyc(1, 16'h2222, 0, 0, 0, 0);
    cyc(1, 16'h3333, 0, 0, 0, 0);
    checks++; if (fe_queue_o !== 16'h1111) $display("FAIL roll_head_a got %h want 1111", fe_queue_o); else passed++;
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (fe_queue_v_o !== 1'b0) $display("FAIL roll_all_read_v got %b want 0", fe_queue_v_o); else passed++;
    cyc(0, 0, 0, 1, 0, 0);
    checks++; if (count_o !== 3'd2) $display("FAIL roll_precount got %0d want 2", count_o); else passed++;
    cyc(0, 0, 0, 0, 1, 0);
    checks++; if (fe_queue_v_o !== 1'b1) $display("FAIL roll_v got %b want 1", fe_queue_v_o); else passed++;
    checks++; if (fe_queue_o !== 16'h2222) $display("FAIL roll_head_b got %h want 2222", fe_queue_o); else passed++;
    checks++; if (count_o !== 3'd2) $display("FAIL roll_count got %0d want 2", count_o); else passed++;
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (fe_queue_o !== 16'h3333) $display("FAIL roll_head_c got %h want 3333", fe_queue_o); else passed++;
    checks++; if (count_o !== 3'd2) $display("FAIL roll_count_after_yumi got %0d want 2", count_o); else passed++;
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    checks++; if (count_o !== 3'd0) $display("FAIL roll_final_count got %0d want 0", count_o); else passed++;
  endtask

  task automatic test_commit_roll;
    cyc(1, 16'h4444, 0, 0, 0, 0);
    cyc(1, 16'h5555, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    checks++; if (fe_queue_o !== 16'h5555) $display("FAIL cr_head got %h want 5555", fe_queue_o); else passed++;
    checks++; if (count_o !== 3'd1) $display("FAIL cr_count got %0d want 1", count_o); else passed++;
    checks++; if (fe_queue_v_o !== 1'b1) $display("FAIL cr_v got %b want 1", fe_queue_v_o); else passed++;
    cyc(0, 0, 1, 1, 0, 0);
    checks++; if (count_o !== 3'd0) $display("FAIL cr_final_count got %0d want 0", count_o); else passed++;
  endtask

  task automatic test_clear;
    cyc(1, 16'h6001, 0, 0, 0, 0);
    cyc(1, 16'h6002, 0, 0, 0, 0);
    cyc(1, 16'h6003, 0, 0, 0, 0);
    checks++; if (count_o !== 3'd3) $display("FAIL clr_pre_count got %0d want 3", count_o); else passed++;
    cyc(1, 16'h6BAD, 1, 1, 0, 1);
    checks++; if (fe_queue_v_o !== 1'b0) $display("FAIL clr_v got %b want 0", fe_queue_v_o); else passed++;
    checks++; if (count_o !== 3'd0) $display("FAIL clr_count got %0d want 0", count_o); else passed++;
    checks++; if (fe_queue_ready_o !== 1'b1) $display("FAIL clr_ready got %b want 1", fe_queue_ready_o); else passed++;
    cyc(0, 0, 0, 0, 0, 0);
    checks++; if (fe_queue_v_o !== 1'b0) $display("FAIL clr_enq_lost_v got %b want 0", fe_queue_v_o); else passed++;
    cyc(1, 16'h6777, 0, 0, 0, 0);
    checks++; if (fe_queue_o !== 16'h6777) $display("FAIL clr_next_head got %h want 6777", fe_queue_o); else passed++;
    checks++; if (count_o !== 3'd1) $display("FAIL clr_next_count got %0d want 1", count_o); else passed++;
    cyc(0, 0, 1, 1, 0, 0);
  endtask

  task automatic test_wrap;
    logic [15:0] model_q[$];
    logic [15:0] exp_v;
    int n, gap;
    for (int round = 0; round < 10; round++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        exp_v = 16'h7000 + 16'(round * 16 + k);
        model_q.push_back(exp_v);
        cyc(1, exp_v, 0, 0, 0, 0);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0, 0, 0);
      checks++; if (count_o !== 3'(n)) $display("FAIL wrap_count r%0d got %0d want %0d", round, count_o, n); else passed++;
      while (model_q.size() > 0) begin
        exp_v = model_q.pop_front();
        checks++; if (fe_queue_o !== exp_v) $display("FAIL wrap_head r%0d got %h want %h", round, fe_queue_o, exp_v); else passed++;
        checks++; if (count_o > 3'd4) $display("FAIL wrap_count_bound r%0d got %0d want <=4", round, count_o); else passed++;
        cyc(0, 0, 1, 1, 0, 0);
      end
      checks++; if (fe_queue_v_o !== 1'b0) $display("FAIL wrap_empty r%0d got %b want 0", round, fe_queue_v_o); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    cyc(1, 16'h8001, 0, 0, 0, 0);
    cyc(1, 16'h8002, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    reset_i = 1'b1;
    cyc(1, 16'h8003, 0, 0, 1, 0);
    reset_i = 1'b0;
    checks++; if (fe_queue_v_o !== 1'b0) $display("FAIL rst_mid_v got %b want 0", fe_queue_v_o); else passed++;
    checks++; if (fe_queue_ready_o !== 1'b1) $display("FAIL rst_mid_ready got %b want 1", fe_queue_ready_o); else passed++;
    checks++; if (count_o !== 3'd0) $display("FAIL rst_mid_count got %0d want 0", count_o); else passed++;
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_rollback;
    test_commit_roll;
    test_clear;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_fifo.md
# bp_fe_queue_fifo

Checkpointed FIFO between the front end's fetch-queue output and the back end's issue/decode stage. It buffers fetch-queue packets (instructions and exceptions) with a ready/valid enqueue port and a valid/yumi dequeue port. Dequeues are speculative, tracked by a read pointer separate from a commit pointer, so the back end can roll back to the last committed entry or clear the queue on a redirect.

## Interface
- `els_p`, 8, number of entries; a power of 2, at least 2.
- `entry_width_p`, `fe_queue_width_lp`, width of one fetch-queue packet.
- `ptr_width_lp`, `$clog2(els_p)+1`, pointer width including the wrap bit (derived, not overridable).

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `fe_queue_i`  in  `entry_width_p`  packet to enqueue.
- `fe_queue_v_i`  in  1  enqueue valid.
- `fe_queue_ready_o`  out  1  not full; enqueue occurs when `fe_queue_v_i & fe_queue_ready_o`.
- `fe_queue_o`  out  `entry_width_p`  entry at the read pointer.
- `fe_queue_v_o`  out  1  read pointer is not equal to the write pointer.
- `fe_queue_yumi_i`  in  1  consume the head entry; legal only while `fe_queue_v_o` is high.
- `commit_v_i`  in  1  retire the oldest speculatively-read entry (advances the commit pointer by 1).
- `roll_v_i`  in  1  restore the read pointer to the commit pointer.
- `clr_v_i`  in  1  discard all entries.
- `count_o`  out  `ptr_width_lp`  occupancy, equal to `wptr - cptr` (committed-pending plus unread entries).

## Operation
- State:
  - three registered pointers `wptr`, `rptr`, `cptr`, each `ptr_width_lp` wide with a wrap bit;
  - storage is `els_p x entry_width_p`, synchronous write and asynchronous read, indexed by the pointer's low bits.
- Full and empty:
  - full = (low bits equal) and (wrap bits differ) between `wptr` and `cptr`;
  - `fe_queue_ready_o = ~full`;
  - `fe_queue_v_o = (rptr != wptr)`.
- Invariant: `cptr <= rptr <= wptr` in modular order, with `wptr - cptr <= els_p`.
- Per-cycle update, in priority order:
  1. `reset_i`: all pointers go to 0.
  2. `clr_v_i`: `rptr <= wptr`, `cptr <= wptr`. The enqueue, yumi, commit and roll inputs are ignored that cycle, and the write is suppressed.
  3. Otherwise the following are evaluated independently:
     - enqueue: write at `wptr`, then `wptr+1`;
     - commit: `cptr+1`;
     - read pointer: roll sets `rptr <= cptr_next`, where `cptr_next` already includes any commit in the same cycle; otherwise yumi gives `rptr+1`. A yumi in the same cycle as a roll is discarded.
- Pointer arithmetic wraps modulo 2·`els_p` and needs no explicit wrap logic.
- Rollback replays entries in the original order. Entries between `cptr` and `rptr` are retained until committed, cleared or overwritten. They cannot be overwritten while uncommitted, because the full check uses `cptr`.
- Illegal inputs (simulation assertions, guarded by `~reset_i`):
  - `fe_queue_yumi_i` with `~fe_queue_v_o`;
  - `commit_v_i` when `cptr == rptr` and no yumi is in flight, i.e. committing an unread entry;
  - `fe_queue_v_i` while full is not an error: the enqueue simply does not occur.

## Timing
- Reset values:
  - `fe_queue_ready_o = 1`;
  - `fe_queue_v_o = 0`;
  - `count_o = 0`;
  - `fe_queue_o` is don't-care.
- Enqueue-to-visible latency is 1 cycle. There is no write-through bypass, even when the queue is empty.
- All outputs are combinational functions of registered pointers and storage only. There are no input-to-output combinational paths: `fe_queue_ready_o` does not depend on `fe_queue_yumi_i` or `commit_v_i` in the same cycle.
- Freeing space:
  - a commit frees a slot for enqueue in the next cycle;
  - a yumi alone does not free space.
- After `clr_v_i`, `fe_queue_v_o` is 0 and `fe_queue_ready_o` is 1 in the next cycle. An enqueue arriving in the clear cycle is lost, and the upstream sees it as not accepted only through its own redirect.
- After a roll, `fe_queue_o` in the next cycle is the entry at the restored `cptr`.
- `reset_i` asserted mid-operation empties the queue in the next cycle, regardless of the other inputs.

## Test plan
- Fill/drain (`els_p=4`): enqueue A,B,C,D on consecutive cycles:
  - `ready_o` drops after D and `count_o=4`;
  - a 5th enqueue is held off;
  - yumi+commit ×4 yields A,B,C,D in order;
  - the queue ends empty with `ready_o=1`.
- Rollback: enqueue A..C, yumi ×3, commit ×1, then roll. The next outputs are B then C, and `count_o` stays 2 until further commits.
- Same-cycle commit+roll: enqueue A,B, yumi ×2, then assert commit and roll together. The next head is B and `count_o=1`.
- Clear priority: with 3 entries, assert `clr_v_i` together with enqueue, yumi and commit. The next cycle shows `v_o=0`, `count_o=0`, `ready_o=1`, and the clear-cycle enqueue is absent.
- Wrap-around: run 10 enqueue/yumi/commit rounds on a 4-deep queue with random gaps. Output order matches a reference model, and `count_o` is never above 4.
- Reset mid-stream: with 2 entries and a pending roll, pulse `reset_i`. The next cycle shows `v_o=0`, `ready_o=1` and `count_o=0`.
